// File: rtl/sseg_capture.sv
// Seven-segment bus monitor: filters the multiplexed active-low AN/sseg/DP pins and rebuilds
// the eight 6-bit digit codes {dp, blank, hex}, with frame completion and sticky error flags.
module sseg_capture #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] sseg_i,
    input  logic       dp_i,
    input  logic [7:0] an_i,
    input  logic       clear_err_i,
    output logic [5:0] out0_o,
    output logic [5:0] out1_o,
    output logic [5:0] out2_o,
    output logic [5:0] out3_o,
    output logic [5:0] out4_o,
    output logic [5:0] out5_o,
    output logic [5:0] out6_o,
    output logic [5:0] out7_o,
    output logic [7:0] valid_mask_o,
    output logic       frame_done_o,
    output logic       err_multi_o,
    output logic       err_pattern_o
);

    localparam logic [7:0]  SettleMax = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  SettleArm = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SmpIdle   = {8'hFF, 7'h7F, 1'b1};
    localparam logic [6:0]  SegBlank  = 7'h7F;

    // Returns {hit, hex} for an active-low glyph pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = 5'h10;
            7'h79:   res = 5'h11;
            7'h24:   res = 5'h12;
            7'h30:   res = 5'h13;
            7'h19:   res = 5'h14;
            7'h12:   res = 5'h15;
            7'h02:   res = 5'h16;
            7'h78:   res = 5'h17;
            7'h00:   res = 5'h18;
            7'h10:   res = 5'h19;
            7'h08:   res = 5'h1A;
            7'h03:   res = 5'h1B;
            7'h46:   res = 5'h1C;
            7'h21:   res = 5'h1D;
            7'h06:   res = 5'h1E;
            7'h0E:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [15:0] pins;
    logic [15:0] smp_q, smp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  out_q [8];
    logic [5:0]  out_d [8];
    logic [7:0]  valid_q, valid_d;
    logic        done_q, done_d;
    logic        err_multi_q, err_multi_d;
    logic        err_pattern_q, err_pattern_d;

    logic        stable;
    logic        capture;
    logic [7:0]  smp_an;
    logic [6:0]  smp_seg;
    logic        smp_dp;
    logic [7:0]  an_act;
    logic        an_none;
    logic        an_multi;
    logic [2:0]  idx;
    logic [4:0]  glyph;
    logic        store;
    logic [5:0]  code;

    assign pins    = {an_i, sseg_i, dp_i};
    assign stable  = (pins == smp_q);
    // Fires only on the edge that reaches the threshold, so a long hold captures once.
    assign capture = stable && (cnt_q == SettleArm);

    assign smp_an   = smp_q[15:8];
    assign smp_seg  = smp_q[7:1];
    assign smp_dp   = smp_q[0];
    assign an_act   = ~smp_an;
    assign an_none  = (an_act == 8'h00);
    assign an_multi = ((an_act & (an_act - 8'd1)) != 8'h00);
    assign glyph    = decode_glyph(smp_seg);

    always_comb begin
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (an_act[k]) begin
                idx = 3'(k);
            end
        end
    end

    always_comb begin
        smp_d = pins;
        if (!stable) begin
            cnt_d = 8'd1;
        end else if (cnt_q >= SettleMax) begin
            cnt_d = SettleMax;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        out_d         = out_q;
        valid_d       = valid_q;
        done_d        = 1'b0;
        err_multi_d   = err_multi_q & ~clear_err_i;
        err_pattern_d = err_pattern_q & ~clear_err_i;
        store         = 1'b0;
        code          = 6'h00;

        if (capture && !an_none) begin
            if (an_multi) begin
                err_multi_d = 1'b1;
            end else if (smp_seg == SegBlank) begin
                store = 1'b1;
                code  = {~smp_dp, 1'b1, 4'h0};
            end else if (glyph[4]) begin
                store = 1'b1;
                code  = {~smp_dp, 1'b0, glyph[3:0]};
            end else begin
                err_pattern_d = 1'b1;
            end
        end

        if (store) begin
            out_d[idx] = code;
            if ((valid_q | an_act) == 8'hFF) begin
                done_d  = 1'b1;
                valid_d = 8'h00;
            end else begin
                valid_d = valid_q | an_act;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            smp_q         <= SmpIdle;
            cnt_q         <= 8'd0;
            out_q         <= '{default: 6'h00};
            valid_q       <= 8'h00;
            done_q        <= 1'b0;
            err_multi_q   <= 1'b0;
            err_pattern_q <= 1'b0;
        end else begin
            smp_q         <= smp_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            valid_q       <= valid_d;
            done_q        <= done_d;
            err_multi_q   <= err_multi_d;
            err_pattern_q <= err_pattern_d;
        end
    end

    assign out0_o        = out_q[0];
    assign out1_o        = out_q[1];
    assign out2_o        = out_q[2];
    assign out3_o        = out_q[3];
    assign out4_o        = out_q[4];
    assign out5_o        = out_q[5];
    assign out6_o        = out_q[6];
    assign out7_o        = out_q[7];
    assign valid_mask_o  = valid_q;
    assign frame_done_o  = done_q;
    assign err_multi_o   = err_multi_q;
    assign err_pattern_o = err_pattern_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: two instances (settle 2 and 4) on shared pins, directed scenarios
// followed by random pin traffic, all checked against a behavioural run-length model.
module tb_sseg_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       dp  = 1'b1;
    logic [6:0] seg = 7'h7F;
    logic [7:0] an  = 8'hFF;

    logic [5:0] o2 [8];
    logic [5:0] o4 [8];
    logic [7:0] vm2, vm4;
    logic       fd2, fd4, em2, em4, ep2, ep4;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    sseg_capture #(.SETTLE_CYCLES(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .sseg_i(seg), .dp_i(dp), .an_i(an), .clear_err_i(clr),
        .out0_o(o2[0]), .out1_o(o2[1]), .out2_o(o2[2]), .out3_o(o2[3]),
        .out4_o(o2[4]), .out5_o(o2[5]), .out6_o(o2[6]), .out7_o(o2[7]),
        .valid_mask_o(vm2), .frame_done_o(fd2), .err_multi_o(em2), .err_pattern_o(ep2)
    );

    sseg_capture #(.SETTLE_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .sseg_i(seg), .dp_i(dp), .an_i(an), .clear_err_i(clr),
        .out0_o(o4[0]), .out1_o(o4[1]), .out2_o(o4[2]), .out3_o(o4[3]),
        .out4_o(o4[4]), .out5_o(o4[5]), .out6_o(o4[6]), .out7_o(o4[7]),
        .valid_mask_o(vm4), .frame_done_o(fd4), .err_multi_o(em4), .err_pattern_o(ep4)
    );

    // Reference model: instance 0 settles in 2, instance 1 in 4.
    logic [6:0]  glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          settle [2] = '{2, 4};
    logic [5:0]  m_out [2][8];
    logic [7:0]  m_valid [2];
    logic        m_done [2];
    logic        m_em [2];
    logic        m_ep [2];
    logic [15:0] m_last [2];
    int          m_run [2];

    function automatic int glyph_index(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (glyphs[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input int i);
        logic [15:0] p;
        logic [5:0]  code;
        logic        st;
        int          n, k, h;
        if (rst) begin
            for (int j = 0; j < 8; j++) m_out[i][j] = 6'h00;
            m_valid[i] = 8'h00;
            m_done[i]  = 1'b0;
            m_em[i]    = 1'b0;
            m_ep[i]    = 1'b0;
            m_last[i]  = 16'hFFFF;
            m_run[i]   = 0;
            return;
        end
        p          = {an, seg, dp};
        m_run[i]   = (p == m_last[i]) ? m_run[i] + 1 : 1;
        m_last[i]  = p;
        m_done[i]  = 1'b0;
        if (clr) begin
            m_em[i] = 1'b0;
            m_ep[i] = 1'b0;
        end
        if (m_run[i] == settle[i]) begin
            n = $countones(~an);
            if (n > 1) begin
                m_em[i] = 1'b1;
            end else if (n == 1) begin
                k = 0;
                for (int j = 0; j < 8; j++) if (!an[j]) k = j;
                h    = glyph_index(seg);
                st   = 1'b1;
                code = 6'h00;
                if (seg == 7'h7F) code = {~dp, 1'b1, 4'h0};
                else if (h >= 0) code = {~dp, 1'b0, 4'(h)};
                else begin
                    st      = 1'b0;
                    m_ep[i] = 1'b1;
                end
                if (st) begin
                    m_out[i][k]   = code;
                    m_valid[i][k] = 1'b1;
                    if (m_valid[i] == 8'hFF) begin
                        m_done[i]  = 1'b1;
                        m_valid[i] = 8'h00;
                    end
                end
            end
        end
    endtask

    function automatic logic [47:0] pack_dut(input logic [5:0] a [8]);
        logic [47:0] r;
        for (int k = 0; k < 8; k++) r[k*6 +: 6] = a[k];
        return r;
    endfunction

    function automatic logic [47:0] pack_model(input int i);
        logic [47:0] r;
        for (int k = 0; k < 8; k++) r[k*6 +: 6] = m_out[i][k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("d2_outs", pack_dut(o2), pack_model(0));
        chk("d2_valid", 48'(vm2), 48'(m_valid[0]));
        chk("d2_done", 48'(fd2), 48'(m_done[0]));
        chk("d2_err_multi", 48'(em2), 48'(m_em[0]));
        chk("d2_err_pattern", 48'(ep2), 48'(m_ep[0]));
        chk("d4_outs", pack_dut(o4), pack_model(1));
        chk("d4_valid", 48'(vm4), 48'(m_valid[1]));
        chk("d4_done", 48'(fd4), 48'(m_done[1]));
        chk("d4_err_multi", 48'(em4), 48'(m_em[1]));
        chk("d4_err_pattern", 48'(ep4), 48'(m_ep[1]));
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        if (fd2) pulses++;
        compare_all();
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
        an  = a;
        seg = s;
        dp  = d;
        repeat (n) step();
    endtask

    task automatic scan(input int ndig);
        for (int k = 0; k < ndig; k++) hold(~(8'h01 << k), glyphs[k], 1'b1, 4);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_outs", pack_dut(o2), 48'h0);
        chk("rst_valid", 48'(vm2), 48'h0);
        chk("rst_flags", 48'({fd2, em2, ep2}), 48'h0);
        rst = 1'b0;
        hold(8'hFF, 7'h7F, 1'b1, 2);

        // Single digit: one edge after first sample, no recapture
        hold(8'hFB, 7'h08, 1'b0, 1);
        chk("sd_before", 48'(vm2), 48'h0);
        step();
        chk("sd_out2", 48'(o2[2]), 48'h2A);
        chk("sd_mask", 48'(vm2), 48'h04);
        step();
        chk("sd_mask_held", 48'(vm2), 48'h04);
        hold(8'hFF, 7'h7F, 1'b1, 2);

        // Glitch filter on the settle-4 instance
        for (int r = 0; r < 4; r++) begin
            hold(8'hFE, 7'h79, 1'b1, 2);
            hold(8'hFE, 7'h24, 1'b1, 2);
        end
        chk("glitch_no_capture", 48'(vm4), 48'h0);
        hold(8'hFE, 7'h30, 1'b1, 4);
        chk("glitch_out0", 48'(o4[0]), 48'h03);
        chk("glitch_mask", 48'(vm4), 48'h01);
        hold(8'hFF, 7'h7F, 1'b1, 2);

        // Error flags
        hold(8'hF3, 7'h40, 1'b1, 4);
        chk("multi_flag", 48'(em2), 48'h1);
        chk("multi_flag4", 48'(em4), 48'h1);
        hold(8'hFE, 7'h55, 1'b1, 4);
        chk("pattern_flag", 48'(ep2), 48'h1);
        chk("pattern_out0", 48'(o2[0]), 48'h03);
        clr = 1'b1;
        hold(8'hFF, 7'h7F, 1'b1, 1);
        clr = 1'b0;
        chk("clear_both", 48'({em2, ep2}), 48'h0);
        hold(8'hF3, 7'h40, 1'b1, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clear_vs_set", 48'(em2), 48'h1);
        hold(8'hFF, 7'h7F, 1'b1, 2);

        // Blank digit
        hold(8'h7F, 7'h7F, 1'b1, 4);
        chk("blank_out7", 48'(o2[7]), 48'h10);

        // Reset mid-frame, then a full scan
        rst = 1'b1;
        step();
        rst = 1'b0;
        scan(5);
        chk("partial_mask", 48'(vm2), 48'h1F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outs", pack_dut(o2), 48'h0);
        chk("midrst_mask", 48'(vm2), 48'h0);
        pulses = 0;
        scan(8);
        chk("scan_pulses", 48'(pulses), 48'h1);
        chk("scan_mask", 48'(vm2), 48'h0);
        for (int k = 0; k < 8; k++) chk("scan_out", 48'(o2[k]), 48'(k));
        chk("scan_errs", 48'({em2, ep2}), 48'h0);

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            int ra, rs, len;
            logic [7:0] a;
            logic [6:0] s;
            ra = $urandom_range(0, 9);
            rs = $urandom_range(0, 17);
            if (ra < 8) a = ~(8'h01 << ra);
            else if (ra == 8) a = 8'hFF;
            else a = 8'($urandom);
            if (rs < 16) s = glyphs[rs];
            else if (rs == 16) s = 7'h7F;
            else s = 7'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 60) == 0);
            len = $urandom_range(1, 6);
            hold(a, s, 1'($urandom), 1);
            clr = 1'b0;
            rst = 1'b0;
            if (len > 1) repeat (len - 1) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
- Receive-side counterpart of sseg_driver: monitors a multiplexed, active-low seven-segment bus (AN, sseg, DP) and rebuilds the eight 6-bit digit codes that produced it.
- Used as a bench/loopback checker for sseg_driver and as an on-chip display monitor.
- Registers the pins, applies a settle filter, decodes glyphs, stores per-digit values, and flags frame completion and protocol errors.

Parameters:
- SETTLE_CYCLES, 2: consecutive identical samples of {AN, sseg, DP} required before a capture. Legal range is 2..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- sseg  in  7  segment lines, active-low; bit0 = a … bit6 = g
- DP  in  1  decimal point, active-low
- AN  in  8  digit anodes, active-low; AN[k] selects digit k
- clear_err  in  1  synchronous clear of sticky error flags
- out0..out7  out  6 each  reconstructed digit codes
- valid_mask  out  8  bit k set once digit k has been captured in the current frame
- frame_done  out  1  one-cycle pulse when all 8 digits have been captured
- err_multi  out  1  sticky flag: more than one anode was active at a capture
- err_pattern  out  1  sticky flag: an unrecognised segment pattern was captured

Behaviour:
- Digit code format, matching the sseg_driver input encoding:
  - [3:0] hex value
  - [4] blank
  - [5] DP lit
- Reset values:
  - out0..out7 = 0
  - valid_mask = 0
  - frame_done = 0
  - both error flags = 0
  - sample register = {AN=8'hFF, sseg=7'h7F, DP=1}
  - stability counter cnt = 0
- Sampling: every edge, sample register <= pins.
  - If pins equal the sample register, cnt <= min(cnt+1, SETTLE_CYCLES).
  - Otherwise cnt <= 1.
- Capture event: the edge where cnt goes from SETTLE_CYCLES-1 to SETTLE_CYCLES.
  - Exactly one capture per stable window; a window held longer does not recapture.
  - Latency: for pins first sampled at edge E0 and held, the capture is at edge E0+SETTLE_CYCLES-1. Outputs are visible after that edge.
- At capture, using the sampled values:
  - AN = 8'hFF: no action.
  - More than one AN bit low: err_multi <= 1. Nothing stored.
  - Exactly AN[k] low, sseg = 7'h7F: outk <= {~DP, 1, 4'h0}; valid_mask[k] <= 1.
  - Exactly AN[k] low, sseg matches a glyph: outk <= {~DP, 0, hex}; valid_mask[k] <= 1.
  - Exactly AN[k] low, any other pattern: err_pattern <= 1. outk and valid_mask unchanged.
- Glyph table (active-low sseg, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Frame completion:
  - If a store makes valid_mask|(1<<k) == 8'hFF, then on that edge frame_done <= 1 for exactly one cycle and valid_mask <= 0.
  - Outputs hold their values.
  - Digit order is irrelevant. A repeated capture of an already-valid digit overwrites outk and does not affect the frame count.
- Error flags:
  - clear_err clears both flags on the next edge.
  - If a new error occurs on the same edge as clear_err, set wins.
- rst mid-frame returns every register to its reset value on that edge; pins are ignored during reset.
- No combinational path from inputs to outputs.

Test Plan:
- Loopback: sseg_driver with in0..in7 = 0..7, outputs tied to this block, SETTLE=2.
  - Required: out0..out7 = 0..7 and frame_done pulses once per full scan.
  - valid_mask returns to 0 after each pulse; no error flags.
- Direct single-digit capture: AN=8'hFB, sseg=7'h08, DP=0 held 3 cycles.
  - Required: out2 = 6'h2A, valid_mask = 8'h04.
  - Capture occurs exactly 1 edge after first sample; no second capture.
- Glitch filter, SETTLE=4: pins toggle between two values every 2 cycles.
  - Required: no capture.
  - A subsequent hold of 4 cycles captures once.
- Errors:
  - AN=8'hF3 held: err_multi=1, nothing stored.
  - AN=8'hFE with sseg=7'h55: err_pattern=1, out0 unchanged.
  - clear_err alone clears both flags.
  - clear_err coinciding with a new error leaves that flag at 1.
- Blank and rst:
  - AN=8'h7F, sseg=7'h7F, DP=1: out7 = 6'h10.
  - Assert rst after 5 digits have been captured: everything returns to 0 on the next edge.
  - A fresh full scan then yields frame_done exactly once.
